branch_resolve_ctrl: RTL and testbench

Sequences branch resolution in the ID stage of the 5-stage pipelined MIPS CPU. Detects operand hazards for the branch condition, stalls PC and IF/ID for the required number of cycles, then samples the branch-condition result and issues the PC redirect and the optional IF/ID flush. Keeps 32-bit performance counters for branches, taken branches and stall cycles. Sits between the ID-stage decoder, the branch-condition unit, the hazard/forwarding signals from EX/MEM, and the PC mux.

---
 rtl/branch_resolve_ctrl.sv | 76 +++++++
 tb/tb_branch_resolve_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch hazard stall, resolve, PC redirect and perf counters
// Ports: clk/rst/hold control; br_* branch in ID; ex_*/mem_* producer info for hazards;
// stall_id/pc_redirect/pc_target/flush_if_id pipeline controls; cnt_* 32-bit wrapping counters.
module branch_resolve_ctrl #(
  parameter int DELAY_SLOT = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  br_valid,
  input  logic [2:0]            br_type,
  input  logic [REG_ADDR_W-1:0] br_rs,
  input  logic [REG_ADDR_W-1:0] br_rt,
  input  logic [31:0]           br_target,
  input  logic                  br_permit,
  input  logic                  ex_wr_en,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_wr_addr,
  input  logic                  mem_wr_en,
  input  logic                  mem_is_load,
  input  logic [REG_ADDR_W-1:0] mem_wr_addr,
  output logic                  stall_id,
  output logic                  pc_redirect,
  output logic [31:0]           pc_target,
  output logic                  flush_if_id,
  output logic [31:0]           cnt_branch,
  output logic [31:0]           cnt_taken,
  output logic [31:0]           cnt_stall
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] cnt_branch_q, cnt_taken_q, cnt_stall_q;
  logic        active, use_rt, ex_hit, mem_hit, resolve;
  logic [1:0]  need;
  always_comb begin
    active  = br_valid && (br_type inside {[3'd1:3'd6]});
    use_rt  = br_type == 3'd3 || br_type == 3'd4;
    // a zero destination never matches, which also covers sources equal to $0
    ex_hit  = ex_wr_en && ex_wr_addr != '0 &&
              (br_rs == ex_wr_addr || (use_rt && br_rt == ex_wr_addr));
    mem_hit = mem_wr_en && mem_wr_addr != '0 &&
              (br_rs == mem_wr_addr || (use_rt && br_rt == mem_wr_addr));
    need    = (ex_hit && ex_is_load) ? 2'd2 : (ex_hit || (mem_hit && mem_is_load)) ? 2'd1 : 2'd0;
    // in STALL the held branch is resolved regardless of how br_* look now
    stall_id    = !hold && (state_q == IDLE ? (active && need != 2'd0) : cnt_q != 2'd0);
    resolve     = !hold && (state_q == IDLE ? (active && need == 2'd0) : cnt_q == 2'd0);
    pc_redirect = resolve && br_permit;
    pc_target   = pc_redirect ? br_target : 32'd0;
    flush_if_id = pc_redirect && (DELAY_SLOT == 0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      cnt_branch_q <= 32'd0;
      cnt_taken_q  <= 32'd0;
      cnt_stall_q  <= 32'd0;
    end else if (!hold) begin
      if (state_q == IDLE && stall_id) begin
        state_q <= STALL;
        cnt_q   <= need - 2'd1;
      end else if (state_q == STALL) begin
        state_q <= cnt_q == 2'd0 ? IDLE : STALL;
        cnt_q   <= cnt_q == 2'd0 ? 2'd0 : cnt_q - 2'd1;
      end
      cnt_branch_q <= cnt_branch_q + {31'd0, resolve};
      cnt_taken_q  <= cnt_taken_q + {31'd0, pc_redirect};
      cnt_stall_q  <= cnt_stall_q + {31'd0, stall_id};
    end
  end
  assign cnt_branch = cnt_branch_q;
  assign cnt_taken  = cnt_taken_q;
  assign cnt_stall  = cnt_stall_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed vectors for branch_resolve_ctrl with and without delay slot
module tb_branch_resolve_ctrl;
  logic        clk = 1'b0, rst = 1'b0, hold = 1'b0;
  logic        br_valid = 1'b0, br_permit = 1'b0;
  logic [2:0]  br_type = 3'd0;
  logic [4:0]  br_rs = 5'd0, br_rt = 5'd0, ex_wr_addr = 5'd0, mem_wr_addr = 5'd0;
  logic [31:0] br_target = 32'd0;
  logic        ex_wr_en = 1'b0, ex_is_load = 1'b0, mem_wr_en = 1'b0, mem_is_load = 1'b0;
  logic        stall_id, pc_redirect, flush_if_id, flush0;
  logic [31:0] pc_target, cnt_branch, cnt_taken, cnt_stall;
  logic        stall0, redir0;
  logic [31:0] target0, cb0, ct0, cs0;
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DELAY_SLOT(1), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .br_valid(br_valid), .br_type(br_type),
    .br_rs(br_rs), .br_rt(br_rt), .br_target(br_target), .br_permit(br_permit),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
    .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_addr(mem_wr_addr),
    .stall_id(stall_id), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush_if_id(flush_if_id), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
    .cnt_stall(cnt_stall));

  branch_resolve_ctrl #(.DELAY_SLOT(0), .REG_ADDR_W(5)) dut0 (
    .clk(clk), .rst(rst), .hold(hold), .br_valid(br_valid), .br_type(br_type),
    .br_rs(br_rs), .br_rt(br_rt), .br_target(br_target), .br_permit(br_permit),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
    .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_addr(mem_wr_addr),
    .stall_id(stall0), .pc_redirect(redir0), .pc_target(target0),
    .flush_if_id(flush0), .cnt_branch(cb0), .cnt_taken(ct0), .cnt_stall(cs0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic br(input logic v, input logic [2:0] t, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [31:0] tgt, input logic p);
    br_valid = v; br_type = t; br_rs = rs; br_rt = rt; br_target = tgt; br_permit = p;
  endtask

  task automatic haz(input logic ee, input logic el, input logic [4:0] ea,
                     input logic me, input logic ml, input logic [4:0] ma);
    ex_wr_en = ee; ex_is_load = el; ex_wr_addr = ea;
    mem_wr_en = me; mem_is_load = ml; mem_wr_addr = ma;
  endtask

  task automatic outs(input string tag, input logic s, input logic r, input logic [31:0] tgt, input logic f);
    #1;
    chk({tag, ".stall"}, {31'd0, stall_id}, {31'd0, s});
    chk({tag, ".redir"}, {31'd0, pc_redirect}, {31'd0, r});
    chk({tag, ".target"}, pc_target, tgt);
    chk({tag, ".flush"}, {31'd0, flush_if_id}, {31'd0, f});
  endtask

  task automatic cnts(input string tag, input logic [31:0] b, input logic [31:0] t, input logic [31:0] s);
    chk({tag, ".cnt_branch"}, cnt_branch, b);
    chk({tag, ".cnt_taken"}, cnt_taken, t);
    chk({tag, ".cnt_stall"}, cnt_stall, s);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1; tick; rst = 1'b0;
    outs("reset", 0, 0, 32'd0, 0);
    cnts("reset", 0, 0, 0);

    br(1, 3'd3, 5'd1, 5'd2, 32'h00400020, 1);
    outs("beq_nohaz", 0, 1, 32'h00400020, 0);
    chk("beq_nohaz.flush_ds0", {31'd0, flush0}, 32'd1);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("beq_nohaz", 1, 1, 0);

    br(1, 3'd4, 5'd1, 5'd2, 32'h100, 1); haz(1, 1, 5'd2, 0, 0, 0);
    outs("bne_lw_c1", 1, 0, 32'd0, 0);
    tick; outs("bne_lw_c2", 1, 0, 32'd0, 0);
    tick; outs("bne_lw_res", 0, 1, 32'h100, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("bne_lw", 2, 2, 2);

    br(1, 3'd2, 5'd1, 5'd2, 32'h180, 0);
    outs("bgez_rt_ignored", 0, 0, 32'd0, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("bgez_rt_ignored", 3, 2, 2);

    br(1, 3'd6, 5'd3, 5'd0, 32'h200, 0); haz(1, 0, 5'd3, 0, 0, 0);
    outs("bgtz_alu_c1", 1, 0, 32'd0, 0);
    tick; outs("bgtz_alu_res", 0, 0, 32'd0, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("bgtz_alu", 4, 2, 3);

    br(1, 3'd6, 5'd0, 5'd0, 32'h240, 1); haz(1, 1, 5'd0, 0, 0, 0);
    outs("bgtz_r0", 0, 1, 32'h240, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("bgtz_r0", 5, 3, 3);

    br(1, 3'd3, 5'd5, 5'd6, 32'h280, 1); haz(0, 0, 0, 1, 1, 5'd6);
    outs("beq_memld_c1", 1, 0, 32'd0, 0);
    tick; outs("beq_memld_res", 0, 1, 32'h280, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("beq_memld", 6, 4, 4);

    br(1, 3'd3, 5'd5, 5'd6, 32'h2c0, 1); haz(0, 0, 0, 1, 0, 5'd6);
    outs("beq_memalu", 0, 1, 32'h2c0, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0); haz(0, 0, 0, 0, 0, 0);
    cnts("beq_memalu", 7, 5, 4);

    br(1, 3'd5, 5'd7, 5'd0, 32'h300, 1);
    outs("blez_ds1", 0, 1, 32'h300, 0);
    chk("blez_ds0.flush", {31'd0, flush0}, 32'd1);
    chk("blez_ds0.target", target0, 32'h300);
    tick; br(0, 3'd0, 0, 0, 0, 0); #1;
    chk("blez_ds0.flush_after", {31'd0, flush0}, 32'd0);
    chk("blez_ds0.cnt_taken", ct0, 32'd6);

    br(1, 3'd7, 5'd1, 5'd2, 32'h340, 1);
    outs("type7_transparent", 0, 0, 32'd0, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("type7_transparent", 8, 6, 4);

    br(1, 3'd4, 5'd1, 5'd2, 32'h400, 1); haz(1, 1, 5'd2, 0, 0, 0);
    outs("hold_c1", 1, 0, 32'd0, 0);
    tick; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      outs("hold_frozen", 0, 0, 32'd0, 0);
      tick;
      cnts("hold_frozen", 8, 6, 5);
    end
    hold = 1'b0;
    outs("hold_c2", 1, 0, 32'd0, 0);
    tick; outs("hold_res", 0, 1, 32'h400, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("hold", 9, 7, 6);

    br(1, 3'd4, 5'd1, 5'd2, 32'h440, 1);
    outs("rst_c1", 1, 0, 32'd0, 0);
    tick; rst = 1'b1; br(0, 3'd0, 0, 0, 0, 0); haz(0, 0, 0, 0, 0, 0);
    tick; rst = 1'b0;
    outs("rst_midstall", 0, 0, 32'd0, 0);
    cnts("rst_midstall", 0, 0, 0);
    br(1, 3'd3, 5'd1, 5'd2, 32'h500, 1);
    outs("after_rst", 0, 1, 32'h500, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0);
    cnts("after_rst", 1, 1, 0);

    br(1, 3'd6, 5'd3, 5'd0, 32'h600, 0); haz(1, 0, 5'd3, 0, 0, 0);
    force dut.cnt_stall_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_stall_q;
    outs("wrap_stall", 1, 0, 32'd0, 0);
    chk("wrap_pre", cnt_stall, 32'hFFFFFFFF);
    tick;
    chk("wrap_post", cnt_stall, 32'd0);
    outs("wrap_res", 0, 0, 32'd0, 0);
    tick; br(0, 3'd0, 0, 0, 0, 0); haz(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
